// File: rtl/code_history_if.sv
// Capture-history bus: live code, switch and control inputs toward the buffer,
// scrolled display window and status flags back to the segment drivers.
interface code_history_if #(
  parameter int p_width = 6,
  parameter int p_depth = 8,
  parameter int p_win   = 4
);
  localparam int c_cw = $clog2(p_depth + 1);
  localparam int c_ow = ((p_depth - p_win + 1) > 1) ? $clog2(p_depth - p_win + 1) : 1;

  logic [p_width-1:0] i_val;
  logic               i_cap;
  logic               i_freeze;
  logic               i_clr;
  logic               i_up;
  logic               i_dn;
  logic [p_width-1:0] o_win [p_win];
  logic [c_cw-1:0]    o_cnt;
  logic [c_ow-1:0]    o_ofs;
  logic               o_new;
  logic               o_ovf;

  modport master (
    output i_val, i_cap, i_freeze, i_clr, i_up, i_dn,
    input  o_win, o_cnt, o_ofs, o_new, o_ovf
  );

  modport slave (
    input  i_val, i_cap, i_freeze, i_clr, i_up, i_dn,
    output o_win, o_cnt, o_ofs, o_new, o_ovf
  );
endinterface

// File: rtl/code_history.sv
// Newest-first capture history of a display code, written on qualified edges of a
// synchronised switch, with a scrollable registered window for the segment drivers.
module code_history #(
  parameter int                 p_width = 6,
  parameter int                 p_depth = 8,
  parameter int                 p_win   = 4,
  parameter int                 p_sync  = 2,
  parameter int                 p_edge  = 0,
  parameter logic [p_width-1:0] p_blank = 6'h3F
) (
  input  logic          i_clk,
  input  logic          i_rst,
  code_history_if.slave bus
);
  localparam int c_cw  = $clog2(p_depth + 1);
  localparam int c_ow  = ((p_depth - p_win + 1) > 1) ? $clog2(p_depth - p_win + 1) : 1;
  localparam int c_wuw = $clog2(p_sync + 2);
  localparam logic [c_ow-1:0]  c_ofs_max = c_ow'(p_depth - p_win);
  localparam logic [c_cw-1:0]  c_full    = c_cw'(p_depth);
  localparam logic [c_wuw-1:0] c_wu_init = c_wuw'(p_sync + 1);

  logic [p_sync-1:0]  sync_q;
  logic               dly_q;
  logic [c_wuw-1:0]   wu_q;
  logic [p_width-1:0] ent_q [p_depth];
  logic [p_width-1:0] ent_d [p_depth];
  logic [c_cw-1:0]    cnt_q, cnt_d;
  logic [c_cw-1:0]    ocnt_q, ocnt_d;
  logic [c_ow-1:0]    ofs_q, ofs_d;
  logic               ovf_q, ovf_d;
  logic               new_q, new_d;
  logic [p_width-1:0] win_q [p_win];
  logic [p_width-1:0] win_d [p_win];
  logic               rise_s, fall_s, edge_s, evt_s;

  assign rise_s = sync_q[p_sync-1] & ~dly_q;
  assign fall_s = ~sync_q[p_sync-1] & dly_q;
  assign edge_s = (p_edge == 1) ? rise_s : (rise_s | fall_s);
  // Warm-up hides the artificial edge a switch held high through reset would produce.
  assign evt_s  = edge_s & ~bus.i_freeze & (wu_q == {c_wuw{1'b0}});

  assign bus.o_win = win_q;
  assign bus.o_cnt = ocnt_q;
  assign bus.o_ofs = ofs_q;
  assign bus.o_new = new_q;
  assign bus.o_ovf = ovf_q;

  always_comb begin
    ent_d  = ent_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    new_d  = 1'b0;
    ocnt_d = cnt_q;

    if (bus.i_up && !bus.i_dn && (ofs_q < c_ofs_max)) begin
      ofs_d = ofs_q + c_ow'(1);
    end else if (bus.i_dn && !bus.i_up && (ofs_q != {c_ow{1'b0}})) begin
      ofs_d = ofs_q - c_ow'(1);
    end else begin
      ofs_d = ofs_q;
    end

    if (evt_s) begin
      ent_d[0] = bus.i_val;
      for (int k = 1; k < p_depth; k++) begin
        ent_d[k] = ent_q[k-1];
      end
      if (cnt_q == c_full) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + c_cw'(1);
      end
      new_d = 1'b1;
    end else begin
      new_d = 1'b0;
    end

    // Every slot is built from the current-cycle offset and count, never from next state.
    for (int j = 0; j < p_win; j++) begin
      win_d[j] = p_blank;
      for (int k = 0; k < p_depth; k++) begin
        if ((k == (int'(ofs_q) + j)) && (k < int'(cnt_q))) begin
          win_d[j] = ent_q[k];
        end else begin
          win_d[j] = win_d[j];
        end
      end
    end

    if (bus.i_clr) begin
      for (int k = 0; k < p_depth; k++) begin
        ent_d[k] = {p_width{1'b0}};
      end
      for (int j = 0; j < p_win; j++) begin
        win_d[j] = p_blank;
      end
      cnt_d  = {c_cw{1'b0}};
      ocnt_d = {c_cw{1'b0}};
      ofs_d  = {c_ow{1'b0}};
      ovf_d  = 1'b0;
      new_d  = 1'b0;
    end else begin
      ocnt_d = cnt_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= {p_sync{1'b0}};
      dly_q  <= 1'b0;
      wu_q   <= c_wu_init;
      for (int k = 0; k < p_depth; k++) begin
        ent_q[k] <= {p_width{1'b0}};
      end
      for (int j = 0; j < p_win; j++) begin
        win_q[j] <= p_blank;
      end
      cnt_q  <= {c_cw{1'b0}};
      ocnt_q <= {c_cw{1'b0}};
      ofs_q  <= {c_ow{1'b0}};
      ovf_q  <= 1'b0;
      new_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[p_sync-2:0], bus.i_cap};
      dly_q  <= sync_q[p_sync-1];
      if (wu_q != {c_wuw{1'b0}}) begin
        wu_q <= wu_q - c_wuw'(1);
      end else begin
        wu_q <= wu_q;
      end
      ent_q  <= ent_d;
      win_q  <= win_d;
      cnt_q  <= cnt_d;
      ocnt_q <= ocnt_d;
      ofs_q  <= ofs_d;
      ovf_q  <= ovf_d;
      new_q  <= new_d;
    end
  end
endmodule
